// File: rtl/rx_timer_pkg.sv
// Shared types and defaults for the serial receive bit timer.
package rx_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SKIP = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam int DEF_CLKS_PER_BIT = 10;
    localparam int DEF_SAMPLE_POINT = 5;
    localparam int DEF_NUM_BITS     = 9;

    // Width needed to hold the values 0..max_val.
    function automatic int cnt_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/flex_counter.sv
// Wrapping counter: 0 after clear, then 1..rollover, rollover -> 1 with no dead cycle.
module flex_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         i_clear,
    input  logic         i_count_enable,
    input  logic [W-1:0] i_rollover_val,
    output logic [W-1:0] o_count_out,
    output logic [W-1:0] o_count_next
);

    logic [W-1:0] r_count;

    always_comb begin
        o_count_next = r_count;
        if (i_clear)
            o_count_next = '0;
        else if (i_count_enable)
            o_count_next = (r_count == i_rollover_val) ? W'(1) : r_count + W'(1);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) r_count <= '0;
        else        r_count <= o_count_next;
    end

    assign o_count_out = r_count;

endmodule

// File: rtl/rx_bit_timer.sv
// Bit-period timer: skips the start bit, strobes each bit at its sample point, flags frame end.
// Optional stop-bit check enabled by defining RX_TIMER_FRAMING_EN.
module rx_bit_timer
    import rx_timer_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int SAMPLE_POINT = DEF_SAMPLE_POINT,
    parameter int NUM_BITS     = DEF_NUM_BITS
) (
    input  logic                             clk,
    input  logic                             n_rst,
    input  logic                             i_start_bit,
    input  logic                             i_abort,
    input  logic                             i_serial_in,
    output logic                             o_shift_strobe,
    output logic                             o_packet_done,
    output logic                             o_framing_error,
    output logic                             o_busy,
    output logic [cnt_width(NUM_BITS)-1:0]   o_bit_index
);

    localparam int CNT_W = cnt_width(CLKS_PER_BIT);
    localparam int IDX_W = cnt_width(NUM_BITS);
    localparam logic [CNT_W-1:0] C_VAL = CNT_W'(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] S_VAL = CNT_W'(SAMPLE_POINT);
    localparam logic [IDX_W-1:0] N_VAL = IDX_W'(NUM_BITS);

    state_t           r_state, w_state_next;
    logic [CNT_W-1:0] w_clk_cnt, w_clk_cnt_next;
    logic [IDX_W-1:0] w_idx, w_unused_idx_next;
    logic             r_strobe, r_done;
    logic             w_start, w_kill, w_frame_end, w_strobe_next;

    // Abort only matters mid-frame; in IDLE it must leave bit_index alone.
    assign w_start     = (r_state == IDLE) && i_start_bit && !i_abort;
    assign w_kill      = i_abort && (r_state != IDLE);
    assign w_frame_end = (r_state == DATA) && r_strobe && (w_idx == N_VAL) && !i_abort;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_start)              w_state_next = SKIP;
            SKIP:    if (w_clk_cnt == C_VAL)   w_state_next = DATA;
            DATA:    if (w_frame_end)          w_state_next = IDLE;
            default:                           w_state_next = IDLE;
        endcase
        if (i_abort) w_state_next = IDLE;
    end

    // Strobe is registered, so it is decided from the counter's next value.
    assign w_strobe_next = (w_state_next == DATA) && (w_clk_cnt_next == S_VAL);

    flex_counter #(.W(CNT_W)) u_clk_cnt (
        .clk            (clk),
        .n_rst          (n_rst),
        .i_clear        (w_state_next == IDLE),
        .i_count_enable (1'b1),
        .i_rollover_val (C_VAL),
        .o_count_out    (w_clk_cnt),
        .o_count_next   (w_clk_cnt_next)
    );

    flex_counter #(.W(IDX_W)) u_bit_cnt (
        .clk            (clk),
        .n_rst          (n_rst),
        .i_clear        (w_start || w_kill),
        .i_count_enable (w_strobe_next),
        .i_rollover_val (N_VAL),
        .o_count_out    (w_idx),
        .o_count_next   (w_unused_idx_next)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state  <= IDLE;
            r_strobe <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_strobe <= w_strobe_next;
        end
    end

`ifdef RX_TIMER_FRAMING_EN
    logic r_ferr;

    // Stop bit is the line value in the cycle of the last strobe.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_done <= 1'b0;
            r_ferr <= 1'b0;
        end else begin
            r_done <= w_frame_end && i_serial_in;
            r_ferr <= w_frame_end && !i_serial_in;
        end
    end

    assign o_framing_error = r_ferr;
`else
    logic w_unused_serial;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) r_done <= 1'b0;
        else        r_done <= w_frame_end;
    end

    assign w_unused_serial = i_serial_in;
    assign o_framing_error = 1'b0;
`endif

    assign o_shift_strobe = r_strobe;
    assign o_packet_done  = r_done;
    assign o_busy         = (r_state != IDLE);
    assign o_bit_index    = w_idx;

endmodule
